// File: rtl/dma_busarb_if.sv
// dma_busarb_if: DMA request/grant and Z80 BUSRQ/BUSAK signals of dma_busarb.
// The slave modport is the arbiter; master is the DMA engines plus Z80 pins.
interface dma_busarb_if;
    logic [1:0] req;
    logic [1:0] xfer;
    logic [1:0] grant;
    logic       busrq_n;
    logic       busak_n;
    logic       bus_owned;
    logic       timeout_err;
    modport master (output req, xfer, busak_n, input grant, busrq_n, bus_owned, timeout_err);
    modport slave  (input req, xfer, busak_n, output grant, busrq_n, bus_owned, timeout_err);
endinterface

// File: rtl/dma_busarb.sv
// dma_busarb: Z80 bus-mastership arbiter, round-robin between SD and MP3 DMA.
// Optional BUSAK timeout abort is built only with DMA_BUSARB_TIMEOUT_EN.
module dma_busarb #(
    parameter int BURST_MAX   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1023
) (
    input logic         clk,
    input logic         rst,
    dma_busarb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAITACK, ARB, OWN, GAP, RELEASE} state_t;
    localparam logic [7:0] BMAX = 8'(BURST_MAX);
    if (BURST_MAX < 1 || BURST_MAX > 255 || SYNC_STAGES < 2 || ACK_TIMEOUT < 1) begin : g_bad
        $error("dma_busarb: illegal parameter value");
    end
    state_t state, state_d;
    logic [SYNC_STAGES-1:0] ak_sync;
    logic ak_s, own, win, tmo, err;
    logic rr_last, rr_last_d;
    logic [1:0] grant, grant_d;
    logic busrq_n;
    logic [7:0] burst_cnt, burst_cnt_d, cnt_inc;
    always_ff @(posedge clk or posedge rst)
        if (rst) ak_sync <= '1;
        else ak_sync <= {ak_sync[SYNC_STAGES-2:0], bus.busak_n};
    assign ak_s = ak_sync[SYNC_STAGES-1];
`ifdef DMA_BUSARB_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(ACK_TIMEOUT - 1);
    logic [TW-1:0] tcnt;
    assign tmo = ak_s && tcnt == TLIM;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            tcnt <= (state == WAITACK) ? tcnt + 1'b1 : '0;
            err  <= err | (state == WAITACK && tmo);
        end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    assign own     = grant[1];
    assign cnt_inc = burst_cnt + {7'd0, bus.xfer[own]};
    assign win     = bus.req[~rr_last] ? ~rr_last : rr_last;
    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_last_d   = rr_last;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE:    state_d = (|bus.req && !err) ? WAITACK : IDLE;
            WAITACK: state_d = tmo ? IDLE : (!ak_s ? ARB : WAITACK);
            ARB: begin
                state_d = |bus.req ? OWN : RELEASE;
                if (|bus.req) begin
                    grant_d     = win ? 2'b10 : 2'b01;
                    rr_last_d   = win;
                    burst_cnt_d = '0;
                end
            end
            OWN: begin
                burst_cnt_d = cnt_inc;
                // a full burst yields only if the other side is waiting
                if (!bus.req[own] || (cnt_inc == BMAX && bus.req[~own])) begin
                    state_d = GAP;
                    grant_d = '0;
                end else if (cnt_inc == BMAX) burst_cnt_d = '0;
            end
            GAP:     state_d = |bus.req ? ARB : RELEASE;
            RELEASE: state_d = ak_s ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            busrq_n   <= 1'b1;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            busrq_n   <= !(state_d inside {WAITACK, ARB, OWN, GAP});
            rr_last   <= rr_last_d;
            burst_cnt <= burst_cnt_d;
        end
    assign bus.grant       = grant;
    assign bus.busrq_n     = busrq_n;
    assign bus.bus_owned   = !ak_s && state != IDLE;
    assign bus.timeout_err = err;
endmodule

// File: tb/tb_dma_busarb.sv
// tb_dma_busarb: directed checks of dma_busarb (BURST_MAX=4, SYNC_STAGES=2, ACK_TIMEOUT=8).
module tb_dma_busarb;
    localparam int BM = 4;
    localparam int SS = 2;
    localparam int AT = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    dma_busarb_if bus();
    dma_busarb #(.BURST_MAX(BM), .SYNC_STAGES(SS), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    logic [1:0] rr_seq [12] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10,
                                2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
    initial begin
        bus.req = 2'b00;
        bus.xfer = 2'b00;
        bus.busak_n = 1'b1;
        step(2);
        chk("rst_grant", 8'(bus.grant), 8'h00);
        chk("rst_busrq_n", 8'(bus.busrq_n), 8'h01);
        chk("rst_bus_owned", 8'(bus.bus_owned), 8'h00);
        chk("rst_timeout_err", 8'(bus.timeout_err), 8'h00);
        rst = 1'b0;
        step();
        // first acquisition: Z80 acks two cycles after BUSRQ
        bus.req = 2'b01;
        step();
        chk("acq_busrq_n", 8'(bus.busrq_n), 8'h00);
        step(2);
        bus.busak_n = 1'b0;
        step(3);
        chk("acq_grant_early", 8'(bus.grant), 8'h00);
        step();
        chk("acq_grant", 8'(bus.grant), 8'h01);
        chk("acq_bus_owned", 8'(bus.bus_owned), 8'h01);
        // both requesting, owner strobes every granted cycle
        bus.req = 2'b11;
        for (int k = 0; k < 12; k++) begin
            bus.xfer = bus.grant;
            step();
            chk($sformatf("rr_grant_%0d", k), 8'(bus.grant), 8'(rr_seq[k]));
        end
        // single requester keeps the grant; xfer on bit1 must be ignored
        bus.req = 2'b01;
        bus.xfer = 2'b11;
        for (int k = 0; k < 42; k++) begin
            step();
            chk($sformatf("solo_grant_%0d", k), 8'(bus.grant), 8'h01);
        end
        chk("solo_burst_cnt", dut.burst_cnt, 8'd2);
        // owner drops req in the same cycle as its last xfer
        bus.req = 2'b00;
        bus.xfer = 2'b01;
        step();
        bus.xfer = 2'b00;
        chk("drop_grant", 8'(bus.grant), 8'h00);
        chk("drop_burst_cnt", dut.burst_cnt, 8'd3);
        step();
        chk("rel_busrq_n", 8'(bus.busrq_n), 8'h01);
        step();
        bus.req = 2'b10;
        bus.busak_n = 1'b1;
        step(2);
        chk("rel_wait_busrq_n", 8'(bus.busrq_n), 8'h01);
        chk("rel_bus_owned", 8'(bus.bus_owned), 8'h00);
        step();
        chk("rel_idle_busrq_n", 8'(bus.busrq_n), 8'h01);
        step();
        chk("rerq_busrq_n", 8'(bus.busrq_n), 8'h00);
        // request withdrawn before BUSAK: BUSRQ held until ack, no grant
        bus.req = 2'b00;
        step(3);
        chk("wd_hold_busrq_n", 8'(bus.busrq_n), 8'h00);
        bus.busak_n = 1'b0;
        step(3);
        chk("wd_arb_busrq_n", 8'(bus.busrq_n), 8'h00);
        chk("wd_arb_grant", 8'(bus.grant), 8'h00);
        step();
        chk("wd_rel_busrq_n", 8'(bus.busrq_n), 8'h01);
        chk("wd_rel_grant", 8'(bus.grant), 8'h00);
        bus.busak_n = 1'b1;
        step(3);
        // asynchronous reset in the middle of ownership
        bus.req = 2'b01;
        step();
        bus.busak_n = 1'b0;
        step(4);
        chk("mid_grant", 8'(bus.grant), 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("arst_busrq_n", 8'(bus.busrq_n), 8'h01);
        chk("arst_grant", 8'(bus.grant), 8'h00);
        chk("arst_bus_owned", 8'(bus.bus_owned), 8'h00);
        bus.req = 2'b00;
        bus.busak_n = 1'b1;
        step();
        rst = 1'b0;
        step();
        bus.req = 2'b01;
        step();
        chk("to_busrq_n_start", 8'(bus.busrq_n), 8'h00);
`ifdef DMA_BUSARB_TIMEOUT_EN
        step(AT - 1);
        chk("to_busrq_n_wait", 8'(bus.busrq_n), 8'h00);
        chk("to_err_wait", 8'(bus.timeout_err), 8'h00);
        step();
        chk("to_busrq_n_abort", 8'(bus.busrq_n), 8'h01);
        chk("to_err_set", 8'(bus.timeout_err), 8'h01);
        step(5);
        chk("to_locked_busrq_n", 8'(bus.busrq_n), 8'h01);
`else
        step(3 * AT);
        chk("noto_busrq_n", 8'(bus.busrq_n), 8'h00);
        chk("noto_err", 8'(bus.timeout_err), 8'h00);
`endif
        rst = 1'b1;
        step();
        chk("final_rst_err", 8'(bus.timeout_err), 8'h00);
        chk("final_rst_busrq_n", 8'(bus.busrq_n), 8'h01);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
